// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_iter
//  Purpose  : Iterative AES-128 MixColumns round stage. Sits between ShiftRows
//             and AddRoundKey. It mixes COLS_PER_CYCLE columns per clock and
//             needs N_ITER = 4/COLS_PER_CYCLE busy cycles per block. A bypass
//             request passes the state through unmixed with identical timing,
//             which serves the final AES round.
//  Optional : MIX_COLUMNS_INV_EN adds the 'inv' port. When it is set, the
//             block computes InvMixColumns. bypass takes priority over inv.
//  Ports    : clk             - rising-edge clock
//             reset           - asynchronous, active-high; clears all state
//             enable          - start request, sampled only while idle
//             bypass          - sampled with enable; 1 = copy state unmixed
//             inv             - (MIX_COLUMNS_INV_EN only) sampled with enable
//             in              - state in[row][col], ShiftRows layout
//             mixed_array_out - registered result [row][col]
//             busy            - high while a block is in flight
//             done            - one-cycle pulse when mixed_array_out updates
//  Revision : 1.0 - initial release
// ============================================================================
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  bypass,
`ifdef MIX_COLUMNS_INV_EN
    input  logic                  inv,
`endif
    input  logic [3:0][3:0][7:0]  in,
    output logic [3:0][3:0][7:0]  mixed_array_out,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Configuration
    // ------------------------------------------------------------------------
    localparam int N_ITER = 4 / COLS_PER_CYCLE;

    // The first column of the final iteration. For 4 columns per cycle this
    // value is 0, so the first busy edge is also the last one.
    localparam logic [1:0] C_LAST_COL = 2'(4 - COLS_PER_CYCLE);
    // The step wraps to 0 for 4 columns per cycle. This is harmless because
    // that configuration only needs a single iteration.
    localparam logic [1:0] C_COL_STEP = 2'(COLS_PER_CYCLE % 4);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // ------------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant. The constant is decomposed into the
    // chained powers x, 2x, 4x and 8x. This covers every coefficient of both
    // the forward matrix {2,3,1,1} and the inverse matrix {E,B,D,9}.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2   = xtime(a);
        x4   = xtime(x2);
        x8   = xtime(x4);
        gmul = (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Mix one column a[row]. Each output row uses the coefficient row rotated
    // right by the row number.
    function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a, input logic inv_sel);
        logic [3:0] c0, c1, c2, c3;
        c0 = inv_sel ? 4'hE : 4'h2;
        c1 = inv_sel ? 4'hB : 4'h3;
        c2 = inv_sel ? 4'hD : 4'h1;
        c3 = inv_sel ? 4'h9 : 4'h1;
        mix_col[0] = gmul(a[0], c0) ^ gmul(a[1], c1) ^ gmul(a[2], c2) ^ gmul(a[3], c3);
        mix_col[1] = gmul(a[0], c3) ^ gmul(a[1], c0) ^ gmul(a[2], c1) ^ gmul(a[3], c2);
        mix_col[2] = gmul(a[0], c2) ^ gmul(a[1], c3) ^ gmul(a[2], c0) ^ gmul(a[3], c1);
        mix_col[3] = gmul(a[0], c1) ^ gmul(a[1], c2) ^ gmul(a[2], c3) ^ gmul(a[3], c0);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic [1:0]            col_q,   col_d;
    logic [3:0][3:0][7:0]  work_q,  work_d;
    logic [3:0][3:0][7:0]  out_q,   out_d;
    logic                  byp_q,   byp_d;
    logic                  done_q,  done_d;
    logic                  inv_mode;

`ifdef MIX_COLUMNS_INV_EN
    logic                  inv_q,   inv_d;
    assign inv_mode = inv_q;
`else
    assign inv_mode = 1'b0;
`endif

    // Results of the column lanes for the current iteration, indexed [lane][row].
    logic [COLS_PER_CYCLE-1:0][3:0][7:0] lane_res;

    // ------------------------------------------------------------------------
    // Column lanes: lane k works on column col_q + k of the working register.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        localparam logic [1:0] C_K = 2'(k);
        logic [1:0]      lane_col;
        logic [3:0][7:0] lane_in;

        assign lane_col    = col_q + C_K;
        assign lane_in     = {work_q[3][lane_col], work_q[2][lane_col],
                              work_q[1][lane_col], work_q[0][lane_col]};
        assign lane_res[k] = byp_q ? lane_in : mix_col(lane_in, inv_mode);
    end

    // ------------------------------------------------------------------------
    // State register (FSM and datapath)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
            byp_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            out_q   <= out_d;
            byp_q   <= byp_d;
            done_q  <= done_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_BUSY;
            ST_BUSY: if (col_q == C_LAST_COL) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        col_d  = col_q;
        work_d = work_q;
        out_d  = out_q;
        byp_d  = byp_q;
        done_d = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
        inv_d  = inv_q;
`endif
        if (state_q == ST_IDLE) begin
            if (enable) begin
                work_d = in;
                byp_d  = bypass;
                col_d  = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                inv_d  = inv;
`endif
            end
        end else begin
            // The columns are updated in place. Later iterations only read
            // columns that have not been processed yet.
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                for (int r = 0; r < 4; r++) begin
                    work_d[r][col_q + 2'(k)] = lane_res[k][r];
                end
            end
            col_d = col_q + C_COL_STEP;
            if (col_q == C_LAST_COL) begin
                // Publish the whole block at once. The output never shows a
                // partially mixed state.
                out_d  = work_d;
                done_d = 1'b1;
                col_d  = 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy            = (state_q == ST_BUSY);
        done            = done_q;
        mixed_array_out = out_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mix_columns_iter
//  Purpose  : Self-checking bench for mix_columns_iter. It applies directed
//             vectors, random blocks, back-to-back traffic and a mid-block
//             reset. The results are checked against a matrix-multiply
//             reference model over GF(2^8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

    parameter int COLS_PER_CYCLE = 1;
    localparam int LAT = 4 / COLS_PER_CYCLE;

    typedef logic [3:0][3:0][7:0] state_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   enable;
    logic   bypass;
    state_t din;
    state_t mixed_array_out;
    logic   busy;
    logic   done;
`ifdef MIX_COLUMNS_INV_EN
    logic   inv;
`endif

    int     total = 0;
    int     bad   = 0;
    state_t exp_out;   // what mixed_array_out should currently hold

    mix_columns_iter #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .bypass          (bypass),
`ifdef MIX_COLUMNS_INV_EN
        .inv             (inv),
`endif
        .in              (din),
        .mixed_array_out (mixed_array_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // Full GF(2^8) multiply using shift-and-add with the AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    // mode: 0 = MixColumns, 1 = InvMixColumns, 2 = bypass
    function automatic state_t model(input state_t s, input int mode);
        logic [7:0] coef [4];
        state_t     o;
        if (mode == 2) return s;
        if (mode == 1) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else           coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[r][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    o[r][c] = o[r][c] ^ gf_mul(coef[(j - r + 4) % 4], s[j][c]);
            end
        end
        return o;
    endfunction

    // The vector lists columns 0..3, each column as {row0,row1,row2,row3}.
    function automatic state_t from_cols(input logic [127:0] v);
        state_t s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = v[127 - 32*c - 8*r -: 8];
        return s;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = 8'($urandom);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int mode);
        bypass = (mode == 2);
`ifdef MIX_COLUMNS_INV_EN
        inv    = (mode == 1);
`endif
    endtask

    // Run one block and check done/busy timing, hold behaviour and the
    // result. If noisy is set, enable and in keep toggling while busy.
    task automatic run_block(input state_t d, input int mode, input state_t exp,
                             input bit noisy, input string tag);
        enable = 1'b1;
        din    = d;
        set_mode(mode);
        step();                               // capture edge k
        enable = noisy;
        din    = rand_state();
        set_mode($urandom_range(0, 2));
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s capture: busy=%b done=%b required busy=1 done=0", tag, busy, done);
        end
        for (int i = 1; i <= LAT; i++) begin
            step();                           // edge k+i
            if (noisy) din = rand_state();
            total++;
            if (done !== (i == LAT) || busy !== (i != LAT)) begin
                bad++;
                $display("FAIL %s timing edge+%0d: done=%b busy=%b required done=%b busy=%b",
                         tag, i, done, busy, (i == LAT), (i != LAT));
            end
            if (i == LAT) exp_out = exp;
            total++;
            if (mixed_array_out !== exp_out) begin
                bad++;
                $display("FAIL %s data edge+%0d: got %h required %h", tag, i, mixed_array_out, exp_out);
            end
        end
        enable = 1'b0;
        step();
        total++;
        if (done !== 1'b0 || mixed_array_out !== exp_out) begin
            bad++;
            $display("FAIL %s after-done: done=%b out=%h required done=0 out=%h",
                     tag, done, mixed_array_out, exp_out);
        end
    endtask

    // ---------------------------------------------------------------- tests
    state_t t1_in, t1_out, t2_in, t2_out;

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        din    = '0;
        set_mode(0);
        exp_out = '0;
        #3;
        total++;
        if (mixed_array_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset: out=%h busy=%b done=%b required all zero", mixed_array_out, busy, done);
        end
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (mixed_array_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset-release: out=%h busy=%b done=%b required all zero", mixed_array_out, busy, done);
        end
    endtask

    task automatic test_vectors();
        run_block(t1_in, 0, t1_out, 1'b0, "vec1");
        run_block(t2_in, 0, t2_out, 1'b0, "vec2");
        run_block(t2_in, 2, t2_in,  1'b0, "vec3-bypass");
        total++;
        if (model(t1_in, 0) !== t1_out) begin
            bad++;
            $display("FAIL model-vec1: got %h required %h", model(t1_in, 0), t1_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            state_t d = rand_state();
            int     m;
`ifdef MIX_COLUMNS_INV_EN
            m = $urandom_range(0, 2);
`else
            m = ($urandom % 2 == 1) ? 2 : 0;
`endif
            run_block(d, m, model(d, m), 1'b1, "random");
        end
    endtask

    task automatic test_back_to_back();
        state_t q[$];
        enable = 1'b1;
        for (int n = 0; n < 5 * (LAT + 1); n++) begin
            int m = ($urandom % 2 == 1) ? 2 : 0;
            din = rand_state();
            set_mode(m);
            if (n % (LAT + 1) == 0) q.push_back(model(din, m));
            step();
            if (n % (LAT + 1) == LAT) begin
                exp_out = q.pop_front();
                total++;
                if (done !== 1'b1 || mixed_array_out !== exp_out) begin
                    bad++;
                    $display("FAIL b2b cycle %0d: done=%b out=%h required done=1 out=%h",
                             n, done, mixed_array_out, exp_out);
                end
            end else begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b cycle %0d: done=%b required 0", n, done);
                end
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        enable = 1'b1;
        din    = t2_in;
        set_mode(0);
        step();                 // capture
        enable = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        exp_out = '0;
        total++;
        if (mixed_array_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: out=%h busy=%b done=%b required all zero", mixed_array_out, busy, done);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            total++;
            if (done !== 1'b0 || mixed_array_out !== '0) begin
                bad++;
                $display("FAIL abort-idle %0d: done=%b out=%h required done=0 out=0",
                         i, done, mixed_array_out);
            end
        end
        run_block(t1_in, 0, t1_out, 1'b0, "after-abort");
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inv();
        run_block(t2_out, 1, t2_in, 1'b0, "inv");
        run_block(t2_in,  2, t2_in, 1'b0, "bypass-over-inv");
    endtask
`endif

    initial begin
        t1_in  = from_cols(128'hdb135345_01010101_01010101_01010101);
        t1_out = from_cols(128'h8e4da1bc_01010101_01010101_01010101);
        t2_in  = from_cols(128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c);
        t2_out = from_cols(128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8);

        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef MIX_COLUMNS_INV_EN
        test_inv();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
